wave_capture_ctrl: RTL and testbench
====================================

WAVE_CAPTURE_CTRL -- requirements
Module: wave_capture_ctrl

Interface
REQ-001 SHALL provide parameter: TIMEOUT_SAMPLES, 1024, ARMED-state sample count before forced trigger (used only under REQ-027).
REQ-002 SHALL provide port: clk  input  1  single system clock, all logic rising-edge.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: new_sample_ready  input  1  one-cycle strobe, new_sample_in valid.
REQ-005 SHALL provide port: new_sample_in  input  16  signed two's-complement audio sample.
REQ-006 SHALL provide port: wave_display_idle  input  1  high while display is outside the active waveform region.
REQ-007 SHALL provide port: write_address  output  9  RAM write address, {buffer bit, index[7:0]}.
REQ-008 SHALL provide port: write_enable  output  1  RAM write strobe.
REQ-009 SHALL provide port: write_sample  output  8  unsigned sample to RAM.
REQ-010 SHALL provide port: read_index  output  1  half of the 512-entry RAM the display reads.

Function
REQ-011 SHALL implement FSM states ARMED, ACTIVE, WAIT, encoded in 2 bits; unused encoding returns to ARMED next cycle.
REQ-012 SHALL keep prev_msb = new_sample_in[15] of the last accepted strobe, updated on every new_sample_ready in any state.
REQ-013 ARMED: on new_sample_ready with prev_msb=1 and new_sample_in[15]=0 (positive zero crossing), SHALL enter ACTIVE and write that sample at index 0.
REQ-014 ACTIVE: each new_sample_ready SHALL write one sample at the current index, then increment index (8-bit).
REQ-015 ACTIVE: the write at index 255 SHALL move the FSM to WAIT and wrap index to 0.
REQ-016 write_address SHALL equal {~read_index, index}, never targeting the half being displayed.
REQ-017 write_sample SHALL equal {~new_sample_in[15], new_sample_in[14:8]} (offset binary, 0x8000 -> 0x00, 0x7FFF -> 0xFF).
REQ-018 write_enable, write_address, write_sample SHALL be registered: asserted exactly one cycle after the accepted strobe, write_enable high for one cycle per write.
REQ-019 WAIT: new_sample_ready SHALL not cause writes; on a rising edge of wave_display_idle (registered previous value 0, current 1) SHALL toggle read_index and enter ARMED.
REQ-020 Idle rising edges in ARMED or ACTIVE SHALL be ignored and not remembered.
REQ-021 Simultaneous final ACTIVE write and idle rising edge: write SHALL occur; flip SHALL wait for the next idle rising edge.
REQ-022 read_index SHALL change only per REQ-019; exactly 256 writes occur between consecutive flips.

Reset
REQ-023 reset SHALL asynchronously force: state ARMED, index 0, prev_msb 0, read_index 0, write_enable 0, write_address 0, write_sample 0.
REQ-024 idle-edge register SHALL reset to 1, so an idle already high at release does not count as an edge.
REQ-025 Reset mid-ACTIVE SHALL abandon the partial capture; read_index SHALL not flip.
REQ-026 After reset, a negative sample SHALL precede any trigger (prev_msb=0).

Configuration
REQ-027 With TRIGGER_TIMEOUT_EN defined: a 10-bit-or-wider counter, cleared on ARMED entry, SHALL count strobes in ARMED; the strobe that would make the count reach TIMEOUT_SAMPLES SHALL trigger as in REQ-013 regardless of sign.
REQ-028 Without TRIGGER_TIMEOUT_EN: no counter; ARMED waits indefinitely for a zero crossing.

Verification
REQ-029 Reset, strobes 0xFF00 then 0x0100 -> ACTIVE; write_enable one cycle after second strobe, write_address 0x100, write_sample 0x81.
REQ-030 After trigger, 255 more strobes -> 256 writes total, last address 0x1FF, state WAIT, read_index still 0.
REQ-031 In WAIT, idle 0->1 -> read_index 1 next cycle, ARMED; next capture writes addresses 0x000-0x0FF.
REQ-032 Constant positive samples 0x4000 for 2000 strobes: without macro -> zero writes; with TRIGGER_TIMEOUT_EN -> trigger on strobe 1024, first write_sample 0xC0.
REQ-033 Assert reset after 100 ACTIVE writes -> all outputs 0 immediately; read_index 0; next capture restarts at index 0.
REQ-034 Idle rising edge in same cycle as 256th strobe -> write occurs, no flip; flip only on following idle edge.

Source files
------------

// File: rtl/wave_capture_ctrl.sv
// Zero-crossing triggered capture of 256 samples into the back half of a double-buffered RAM.
// RAM writes land one cycle after the accepted strobe; optional forced trigger under TRIGGER_TIMEOUT_EN.
module wave_capture_ctrl #(
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_sample_ready,
  input  logic [15:0] new_sample_in,
  input  logic        wave_display_idle,
  output logic [8:0]  write_address,
  output logic        write_enable,
  output logic [7:0]  write_sample,
  output logic        read_index
);

  typedef enum logic [1:0] {
    ARMED  = 2'b00,
    ACTIVE = 2'b01,
    WAIT   = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] index, index_nxt;
  logic       read_index_nxt;
  logic       do_write;
  logic       prev_msb;
  logic       idle_q;
  logic       idle_rise;
  logic       zero_cross;
  logic       trigger;

  assign idle_rise  = wave_display_idle & ~idle_q;
  assign zero_cross = prev_msb & ~new_sample_in[15];

`ifdef TRIGGER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_SAMPLES) + 1 > 10) ? $clog2(TIMEOUT_SAMPLES) + 1 : 10;

  logic [CNT_W-1:0] timeout_cnt;
  logic             timeout_hit;

  assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT_SAMPLES - 1));
  assign trigger     = zero_cross | timeout_hit;

  // Every entry into ARMED comes from another state or reset, so clearing outside ARMED suffices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timeout_cnt <= '0;
    else if (state != ARMED)
      timeout_cnt <= '0;
    else if (new_sample_ready)
      timeout_cnt <= timeout_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_SAMPLES == 0);
  assign trigger            = zero_cross;
`endif

  always_comb begin
    state_nxt      = state;
    index_nxt      = index;
    read_index_nxt = read_index;
    do_write       = 1'b0;
    case (state)
      ARMED: begin
        // index is always 0 here, so the trigger sample lands at slot 0
        if (new_sample_ready && trigger) begin
          do_write  = 1'b1;
          index_nxt = 8'd1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (new_sample_ready) begin
          do_write  = 1'b1;
          index_nxt = index + 8'd1;
          if (index == 8'hFF)
            state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (idle_rise) begin
          read_index_nxt = ~read_index;
          state_nxt      = ARMED;
        end
      end
      default: begin
        state_nxt = ARMED;
        index_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ARMED;
      index         <= 8'd0;
      prev_msb      <= 1'b0;
      idle_q        <= 1'b1;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= 9'd0;
      write_sample  <= 8'd0;
    end else begin
      state        <= state_nxt;
      index        <= index_nxt;
      idle_q       <= wave_display_idle;
      read_index   <= read_index_nxt;
      write_enable <= do_write;
      if (new_sample_ready)
        prev_msb <= new_sample_in[15];
      if (do_write) begin
        write_address <= {~read_index, index};
        write_sample  <= {~new_sample_in[15], new_sample_in[14:8]};
      end
    end
  end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl: vector table plus capture/flip/reset/timeout sequences.
module tb_wave_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = 16'h0000;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int total = 0;
  int bad   = 0;

  wave_capture_ctrl #(.TIMEOUT_SAMPLES(1024)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stb;
    logic [15:0] smp;
    logic        idle;
    logic        we;
    logic [8:0]  addr;
    logic [7:0]  ws;
    logic        ri;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic s, input logic [15:0] d, input logic i);
    new_sample_ready  = s;
    new_sample_in     = d;
    wave_display_idle = i;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    new_sample_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int writes;
  int first_wr;
  int first_ws;

  initial begin
    vecs[0] = '{1'b1, 16'hFF00, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 16'h0100, 1'b0, 1'b1, 9'h100, 8'h81, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 9'h100, 8'h81, 1'b0};
    vecs[3] = '{1'b1, 16'h8000, 1'b0, 1'b1, 9'h101, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 16'h7FFF, 1'b0, 1'b1, 9'h102, 8'hFF, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 9'h102, 8'hFF, 1'b0};
    vecs[6] = '{1'b1, 16'h1234, 1'b1, 1'b1, 9'h103, 8'h92, 1'b0};

    #1;
    check("reset_we", write_enable, 0);
    check("reset_addr", write_address, 0);
    check("reset_ws", write_sample, 0);
    check("reset_ri", read_index, 0);
    do_reset();

    for (int v = 0; v < 7; v++) begin
      step(vecs[v].stb, vecs[v].smp, vecs[v].idle);
      check($sformatf("vec%0d_we", v), write_enable, vecs[v].we);
      check($sformatf("vec%0d_addr", v), write_address, vecs[v].addr);
      check($sformatf("vec%0d_ws", v), write_sample, vecs[v].ws);
      check($sformatf("vec%0d_ri", v), read_index, vecs[v].ri);
    end

    // Finish the first capture: 4 writes so far, 252 to go.
    writes = 4;
    for (int k = 0; k < 252; k++) begin
      step(1'b1, 16'h0000, 1'b1);
      if (write_enable) writes++;
    end
    check("cap1_writes", writes, 256);
    check("cap1_last_addr", write_address, 9'h1FF);
    check("cap1_ri", read_index, 0);
    step(1'b1, 16'h0000, 1'b1);
    check("wait_no_write", write_enable, 0);
    step(1'b0, 16'h0000, 1'b0);
    check("wait_ri_before", read_index, 0);
    step(1'b0, 16'h0000, 1'b1);
    check("flip_ri", read_index, 1);

    // Second capture targets the low half; reset it after 100 writes.
    step(1'b1, 16'h8000, 1'b1);
    check("armed_no_write", write_enable, 0);
    step(1'b1, 16'h0100, 1'b1);
    check("cap2_we", write_enable, 1);
    check("cap2_addr", write_address, 9'h000);
    for (int k = 0; k < 99; k++) step(1'b1, 16'h0000, 1'b1);
    check("cap2_addr99", write_address, 9'h063);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_we", write_enable, 0);
    check("mid_rst_addr", write_address, 0);
    check("mid_rst_ws", write_sample, 0);
    check("mid_rst_ri", read_index, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 16'h0100, 1'b1);
    check("post_rst_no_trig", write_enable, 0);
    step(1'b1, 16'h8000, 1'b1);
    step(1'b1, 16'h0100, 1'b0);
    check("cap3_addr0", write_address, 9'h100);
    check("cap3_ws", write_sample, 8'h81);

    // Idle edge coinciding with the 256th write must not flip.
    for (int k = 0; k < 254; k++) step(1'b1, 16'h0000, 1'b0);
    check("cap3_addr254", write_address, 9'h1FE);
    step(1'b1, 16'h0000, 1'b1);
    check("coinc_we", write_enable, 1);
    check("coinc_addr", write_address, 9'h1FF);
    check("coinc_ri", read_index, 0);
    step(1'b0, 16'h0000, 1'b1);
    check("coinc_ri_held", read_index, 0);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    check("coinc_flip", read_index, 1);

    // Constant positive input: trigger only via timeout.
    wave_display_idle = 1'b0;
    do_reset();
    writes   = 0;
    first_wr = 0;
    first_ws = -1;
    for (int k = 1; k <= 2000; k++) begin
      step(1'b1, 16'h4000, 1'b0);
      if (write_enable) begin
        if (writes == 0) begin
          first_wr = k;
          first_ws = write_sample;
        end
        writes++;
      end
    end
`ifdef TRIGGER_TIMEOUT_EN
    check("timeout_writes", writes, 256);
    check("timeout_strobe", first_wr, 1024);
    check("timeout_ws", first_ws, 8'hC0);
`else
    check("no_timeout_writes", writes, 0);
    check("no_timeout_first", first_wr, 0);
`endif
    check("timeout_ri", read_index, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
